// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter
// Shares the write side of an async FIFO between NUM_REQ requesters that all
// live in the write-clock domain. Grants rotate round-robin, each grant is
// capped at MAX_BURST accepted beats, and a grant that stays blocked by wfull
// for MAX_FULL_RETRY consecutive cycles is released with a timeout pulse.
//
// Ports
//   wclk        write clock, all state on posedge
//   wrst        synchronous active-high reset
//   req_valid   per-requester "has a beat"
//   req_data    packed lanes, lane i = req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester "beat accepted this cycle" (one-hot or zero)
//   wfull       FIFO full flag, already in the wclk domain
//   winc        FIFO write enable (combinational from the granted beat)
//   wdata       FIFO write data (lane of the current/last grant)
//   grant_vld   a requester currently holds the grant
//   grant_id    current/last granted requester
//   timeout     one-cycle pulse when a grant is released on full timeout
//   timeout_id  requester that timed out, valid with timeout
//   wr_count    total accepted beats, wraps at 2^32
module afifo_wr_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 4,
  parameter int MAX_FULL_RETRY = 10
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout,
  output logic [$clog2(NUM_REQ)-1:0]    timeout_id,
  output logic [31:0]                   wr_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int RW  = $clog2(MAX_FULL_RETRY + 1);

  // Counter values at which the current beat/blocked cycle is the last one.
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_FULL_RETRY - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
  logic            timeout_q, timeout_d;
  logic [IDW-1:0]  timeout_id_q, timeout_id_d;
  logic [31:0]     wr_count_q, wr_count_d;

  // Unpack the requester lanes.
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Index `offs` positions after `base`, wrapping modulo NUM_REQ (also
  // correct when NUM_REQ is not a power of two).
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offs);
    int sum;
    sum = (int'(base) + offs) % NUM_REQ;
    return IDW'(sum);
  endfunction

  // Round-robin pick: first valid requester after the last grant.
  logic           rr_found;
  logic [IDW-1:0] rr_winner;
  logic [IDW-1:0] rr_cand;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = grant_id_q;
    rr_cand   = grant_id_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = rr_index(grant_id_q, k);
      if (!rr_found && req_valid[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Datapath: only the granted requester can ever produce a write, and the
  // write is gated by wfull and by reset in the same cycle.
  logic in_grant;
  logic granted_valid;
  logic beat;

  assign in_grant      = (state_q == GRANT) && !wrst;
  assign granted_valid = req_valid[grant_id_q];
  assign beat          = in_grant && granted_valid && !wfull;

  assign winc      = beat;
  assign wdata     = lane[grant_id_q];
  assign req_ready = beat ? (NUM_REQ'(1) << grant_id_q) : '0;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    wr_count_d   = wr_count_q + {31'd0, beat};

    case (state_q)
      IDLE: begin
        beat_cnt_d  = '0;
        retry_cnt_d = '0;
        if (rr_found) begin
          grant_id_d = rr_winner;
          state_d    = GRANT;
        end
      end

      GRANT: begin
        if (!granted_valid) begin
          // Requester withdrew: release immediately.
          state_d     = IDLE;
          beat_cnt_d  = '0;
          retry_cnt_d = '0;
        end else if (beat) begin
          retry_cnt_d = '0;
          if (beat_cnt_q == BURST_LAST) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end else begin
          // Blocked by wfull. A beat on the final retry cycle takes the
          // other branch, so the timeout only fires if wfull is still set.
          if (retry_cnt_q == RETRY_LAST) begin
            timeout_d    = 1'b1;
            timeout_id_d = grant_id_q;
            state_d      = IDLE;
            beat_cnt_d   = '0;
            retry_cnt_d  = '0;
          end else begin
            retry_cnt_d = retry_cnt_q + RW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= IDLE;
      grant_id_q   <= IDW'(NUM_REQ - 1);  // so requester 0 wins first
      beat_cnt_q   <= '0;
      retry_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign grant_vld  = (state_q == GRANT);
  assign grant_id   = grant_id_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;
  assign wr_count   = wr_count_q;

endmodule
